sha256_padder: RTL and testbench

Upstream stage of the SHA-256 datapath. Accepts a message as a stream of 64-bit big-endian words, applies FIPS 180-4 padding (0x80 byte, zero fill, 64-bit bit-length) and presents complete 512-bit blocks to the hash core with a valid/ready handshake. It tags the first and last block of each message so the downstream core knows when to re-initialise and when the digest is final.

---
 rtl/sha256_pkg.sv | 27 ++
 rtl/sha256_pad_word.sv | 28 ++
 rtl/sha256_padder.sv | 165 ++++++++++++++++
 tb/tb_sha256_padder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 padding front end.
// Contents: width constants, word/block typedefs, the padder state enum and
// a helper that clamps the last-word byte count into 0..8.
package sha256_pkg;

    localparam int BlockWidth    = 512;
    localparam int DataWidth     = 64;
    localparam int LenWidth      = 64;
    localparam int WordsPerBlock = BlockWidth / DataWidth;

    typedef logic [DataWidth-1:0] sha_word_t;
    // Word 0 is the most significant word, so the array ascends from the MSB.
    typedef logic [0:WordsPerBlock-1][DataWidth-1:0] sha_block_t;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        EMIT      = 2'd1,
        EMIT_PAD  = 2'd2,
        EMIT_LAST = 2'd3
    } padder_state_e;

    // Counts above 8 mean "the whole word".
    function automatic logic [3:0] clamp_bytes(input logic [3:0] b);
        return (b > 4'd8) ? 4'd8 : b;
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Masks an input word to its first bytes_i bytes (big-endian, byte 0 in the
// top byte) and optionally inserts the 0x80 terminator byte right after them.
// Ports:
//   data_i  - raw message word
//   bytes_i - valid bytes, 0..8 (already clamped)
//   pad_i   - place 0x80 at byte bytes_i when it lies inside the word
//   word_o  - masked/padded word
module sha256_pad_word
    import sha256_pkg::*;
(
    input  sha_word_t  data_i,
    input  logic [3:0] bytes_i,
    input  logic       pad_i,
    output sha_word_t  word_o
);

    always_comb begin
        word_o = '0;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < bytes_i) begin
                word_o[63-8*b -: 8] = data_i[63-8*b -: 8];
            end else if (pad_i && (4'(b) == bytes_i)) begin
                word_o[63-8*b -: 8] = 8'h80;
            end
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 64-bit big-endian words into 512-bit blocks,
// appends the 0x80 terminator, zero fill and the 64-bit message bit length,
// and tags the first and last block of each message.
// Ports:
//   clk_i, rst_ni                - clock, asynchronous active-low reset
//   data_i/valid_i/ready_o       - input word stream
//   last_i, bytes_i              - final-word marker and its byte count (0..8)
//   raw_i                        - only with SHA256_PADDER_RAW_EN: message is
//                                  pre-padded, append nothing
//   block_o/block_valid_o/block_ready_i - output block handshake
//   block_first_o, block_last_o  - message boundary tags
// Optional feature macro: SHA256_PADDER_RAW_EN.
module sha256_padder
    import sha256_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DataWidth-1:0]  data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  last_i,
    input  logic [3:0]            bytes_i,
`ifdef SHA256_PADDER_RAW_EN
    input  logic                  raw_i,
`endif
    output logic [BlockWidth-1:0] block_o,
    output logic                  block_valid_o,
    input  logic                  block_ready_i,
    output logic                  block_first_o,
    output logic                  block_last_o
);

    localparam int LastSlot = WordsPerBlock - 1;

    padder_state_e         state_q;
    sha_block_t            buf_q;
    logic [2:0]            wcnt_q;
    logic [LenWidth-1:0]   len_q;
    logic                  first_q;
    // Set when the block in EMIT_PAD still owes the 0x80 byte (message ended
    // exactly on a block boundary).
    logic                  pad_pending_q;

    logic                  accept;
    logic                  hs;
    logic [3:0]            nbytes;
    logic                  raw_eff;
    logic                  pad_place;
    sha_word_t             word_pad;
    logic [LenWidth-1:0]   len_d;
    logic [6:0]            pos;
    logic                  fits;

`ifdef SHA256_PADDER_RAW_EN
    logic raw_q;
    logic in_msg_q;
    // raw_i is taken from the first word; later words use the stored value.
    assign raw_eff = in_msg_q ? raw_q : raw_i;
`else
    assign raw_eff = 1'b0;
`endif

    assign ready_o       = (state_q == FILL);
    assign block_valid_o = (state_q != FILL);
    assign block_last_o  = (state_q == EMIT_LAST);
    assign block_first_o = first_q;
    assign block_o       = buf_q;

    assign accept    = valid_i && ready_o;
    assign hs        = block_valid_o && block_ready_i;
    assign nbytes    = last_i ? clamp_bytes(bytes_i) : 4'd8;
    assign pad_place = last_i && !raw_eff;
    assign len_d     = len_q + {{(LenWidth-7){1'b0}}, nbytes, 3'b000};
    // Byte offset of the terminator inside the block; it plus the 8 length
    // bytes must fit within 64 for a single closing block.
    assign pos       = {1'b0, wcnt_q, 3'b000} + {3'b000, nbytes};
    assign fits      = (pos <= 7'd55);

    sha256_pad_word u_pad_word (
        .data_i  (data_i),
        .bytes_i (nbytes),
        .pad_i   (pad_place),
        .word_o  (word_pad)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= FILL;
            buf_q         <= '0;
            wcnt_q        <= '0;
            len_q         <= '0;
            first_q       <= 1'b1;
            pad_pending_q <= 1'b0;
`ifdef SHA256_PADDER_RAW_EN
            raw_q         <= 1'b0;
            in_msg_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        buf_q[wcnt_q] <= word_pad;
                        len_q         <= len_d;
                        wcnt_q        <= wcnt_q + 3'd1;
`ifdef SHA256_PADDER_RAW_EN
                        raw_q         <= raw_eff;
                        in_msg_q      <= 1'b1;
`endif
                        if (!last_i) begin
                            if (wcnt_q == 3'(LastSlot)) state_q <= EMIT;
                        end else if (raw_eff) begin
                            state_q <= EMIT_LAST;
                        end else begin
                            // A full last word pushes the terminator into the
                            // next slot, or into the next block from slot 7.
                            if (nbytes == 4'd8 && wcnt_q != 3'(LastSlot)) begin
                                buf_q[wcnt_q + 3'd1] <= 64'h8000_0000_0000_0000;
                            end
                            pad_pending_q <= (nbytes == 4'd8) && (wcnt_q == 3'(LastSlot));
                            if (fits) begin
                                buf_q[LastSlot] <= len_d;
                                state_q         <= EMIT_LAST;
                            end else begin
                                state_q <= EMIT_PAD;
                            end
                        end
                    end
                end
                EMIT: begin
                    if (hs) begin
                        buf_q   <= '0;
                        wcnt_q  <= '0;
                        first_q <= 1'b0;
                        state_q <= FILL;
                    end
                end
                EMIT_PAD: begin
                    if (hs) begin
                        buf_q           <= '0;
                        buf_q[LastSlot] <= len_q;
                        if (pad_pending_q) buf_q[0] <= 64'h8000_0000_0000_0000;
                        pad_pending_q   <= 1'b0;
                        wcnt_q          <= '0;
                        first_q         <= 1'b0;
                        state_q         <= EMIT_LAST;
                    end
                end
                EMIT_LAST: begin
                    if (hs) begin
                        buf_q   <= '0;
                        len_q   <= '0;
                        wcnt_q  <= '0;
                        first_q <= 1'b1;
`ifdef SHA256_PADDER_RAW_EN
                        in_msg_q <= 1'b0;
`endif
                        state_q <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: byte-level FIPS 180-4 padding model feeding a
// block scoreboard, a vector table of message lengths, plus hand sequences
// for "abc", backpressure and mid-message reset.
module tb_sha256_padder;
    import sha256_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [63:0]  data_i;
    logic         valid_i;
    logic         ready_o;
    logic         last_i;
    logic [3:0]   bytes_i;
    logic [511:0] block_o;
    logic         block_valid_o;
    logic         block_ready_i;
    logic         block_first_o;
    logic         block_last_o;

    always #5 clk = ~clk;

    sha256_padder dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .last_i        (last_i),
        .bytes_i       (bytes_i),
`ifdef SHA256_PADDER_RAW_EN
        .raw_i         (1'b0),
`endif
        .block_o       (block_o),
        .block_valid_o (block_valid_o),
        .block_ready_i (block_ready_i),
        .block_first_o (block_first_o),
        .block_last_o  (block_last_o)
    );

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } exp_blk_t;

    typedef struct {
        int          nbytes;
        int          rdy_mode;   // 0 always ready, 1 random stalls
        logic        big;        // send bytes_i=15 on a full last word
        int          exp_nblk;
        logic [63:0] exp_len;
    } vec_t;

    exp_blk_t    sb[$];
    exp_blk_t    mon_e;
    logic [7:0]  msg_q[$];
    vec_t        vecs[10];
    int          total = 0;
    int          bad   = 0;
    int          rdy_mode = 0;
    int          blk_cnt = 0;
    logic [63:0] last_w7 = '0;
    logic [511:0] abc_blk;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk512(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Output ready generator; changes away from both clock edges.
    initial begin
        block_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rdy_mode == 0)      block_ready_i = 1'b1;
            else if (rdy_mode == 1) block_ready_i = ($urandom_range(0, 2) != 0);
            else                    block_ready_i = 1'b0;
        end
    end

    // Monitor: a valid&&ready seen at negedge is taken at the next posedge.
    always @(negedge clk) begin
        if (rst_n && block_valid_o && block_ready_i) begin
            blk_cnt++;
            last_w7 = block_o[63:0];
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_block got=%h", block_o);
            end else begin
                mon_e = sb.pop_front();
                chk512("block", block_o, mon_e.blk);
                chk1("first", block_first_o, mon_e.first);
                chk1("last", block_last_o, mon_e.last);
            end
        end
    end

    // Independent byte-oriented padding model over msg_q.
    task automatic push_model();
        logic [7:0]   pad[$];
        logic [63:0]  bits;
        logic [511:0] blk;
        exp_blk_t     e;
        int           nb;
        pad  = msg_q;
        bits = 64'(msg_q.size()) * 64'd8;
        pad.push_back(8'h80);
        while ((pad.size() % 64) != 56) pad.push_back(8'h00);
        for (int i = 7; i >= 0; i--) pad.push_back(bits[8*i +: 8]);
        nb = pad.size() / 64;
        for (int k = 0; k < nb; k++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = pad[64*k + j];
            e.blk   = blk;
            e.first = (k == 0);
            e.last  = (k == nb - 1);
            sb.push_back(e);
        end
    endtask

    task automatic push_abc();
        exp_blk_t e;
        e.blk   = abc_blk;
        e.first = 1'b1;
        e.last  = 1'b1;
        sb.push_back(e);
    endtask

    task automatic send_word(input logic [63:0] w, input logic l, input logic [3:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        data_i  = w;
        valid_i = 1'b1;
        last_i  = l;
        bytes_i = b;
        while (!ready_o && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_o) begin
            total++;
            bad++;
            $display("FAIL ready_timeout got=0 want=1");
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    // Unused tail bytes carry 0xA5 and non-last words carry a bogus count,
    // both of which the padder must ignore.
    task automatic send_msg(input logic big);
        int          n, nw, vb;
        logic [63:0] w;
        logic        l;
        logic [3:0]  b;
        n  = msg_q.size();
        nw = (n == 0) ? 1 : (n + 7) / 8;
        for (int i = 0; i < nw; i++) begin
            vb = n - 8 * i;
            if (vb > 8) vb = 8;
            for (int k = 0; k < 8; k++) begin
                if (k < vb) w[63-8*k -: 8] = msg_q[8*i + k];
                else        w[63-8*k -: 8] = 8'hA5;
            end
            l = (i == nw - 1);
            if (!l)                  b = 4'd3;
            else if (big && vb == 8) b = 4'hF;
            else                     b = 4'(vb);
            send_word(w, l, b);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout pending=%0d want=0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_ready"}, ready_o, 1'b1);
        chk1({tag, "_valid"}, block_valid_o, 1'b0);
        chk512({tag, "_block"}, block_o, '0);
        chk1({tag, "_first"}, block_first_o, 1'b1);
        chk1({tag, "_last"}, block_last_o, 1'b0);
    endtask

    initial begin
        int g;
        data_i  = '0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        bytes_i = '0;
        rst_n   = 1'b0;
        abc_blk = '0;
        abc_blk[511:448] = 64'h6162_6380_0000_0000;
        abc_blk[63:0]    = 64'h18;

        vecs[0] = '{0,   0, 1'b0, 1, 64'd0};
        vecs[1] = '{3,   1, 1'b0, 1, 64'd24};
        vecs[2] = '{55,  0, 1'b0, 1, 64'd440};
        vecs[3] = '{56,  0, 1'b0, 2, 64'h1C0};
        vecs[4] = '{56,  1, 1'b1, 2, 64'h1C0};
        vecs[5] = '{63,  0, 1'b0, 2, 64'd504};
        vecs[6] = '{64,  0, 1'b0, 2, 64'h200};
        vecs[7] = '{64,  1, 1'b1, 2, 64'h200};
        vecs[8] = '{120, 1, 1'b0, 3, 64'd960};
        vecs[9] = '{200, 1, 1'b1, 4, 64'd1600};

        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("post_rst");

        // "abc" with junk in the unused bytes.
        blk_cnt = 0;
        push_abc();
        send_word(64'h6162_63AA_BBCC_DDEE, 1'b1, 4'd3);
        drain();
        chk64("abc_blocks", 64'(blk_cnt), 64'd1);

        foreach (vecs[v]) begin
            rdy_mode = vecs[v].rdy_mode;
            msg_q.delete();
            for (int i = 0; i < vecs[v].nbytes; i++) msg_q.push_back(8'($urandom));
            push_model();
            blk_cnt = 0;
            send_msg(vecs[v].big);
            drain();
            chk64($sformatf("vec%0d_nblk", v), 64'(blk_cnt), 64'(vecs[v].exp_nblk));
            chk64($sformatf("vec%0d_len", v), last_w7, vecs[v].exp_len);
        end
        rdy_mode = 0;
        @(negedge clk);

        // Backpressure: block held for 5 cycles, input stalled meanwhile.
        rdy_mode = 2;
        @(posedge clk);
        #3;
        push_abc();
        send_word(64'h6162_6300_0000_0000, 1'b1, 4'd3);
        g = 0;
        while (!block_valid_o && g < 20) begin
            @(negedge clk);
            g++;
        end
        for (int i = 0; i < 5; i++) begin
            chk512("bp_block", block_o, abc_blk);
            chk1("bp_ready", ready_o, 1'b0);
            chk1("bp_valid", block_valid_o, 1'b1);
            chk1("bp_last", block_last_o, 1'b1);
            @(negedge clk);
        end
        rdy_mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk1("bp_release_ready", ready_o, 1'b1);
        chk1("bp_release_valid", block_valid_o, 1'b0);
        chk64("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Reset in the middle of a message.
        blk_cnt = 0;
        send_word(64'h1111_1111_1111_1111, 1'b0, 4'd8);
        send_word(64'h2222_2222_2222_2222, 1'b0, 4'd8);
        send_word(64'h3333_3333_3333_3333, 1'b0, 4'd8);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        push_abc();
        send_word(64'h6162_6300_0000_0000, 1'b1, 4'd3);
        drain();
        chk64("midrst_blocks", 64'(blk_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
